// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions for decode_stage_pipe: RV32I opcodes,
// control-bundle types, immediate formats and per-opcode control constants.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } ctrl_wb_t;

  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic branch;
  } ctrl_mem_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_exe_t;

  typedef struct packed {
    ctrl_wb_t  wb;
    ctrl_mem_t mem;
    ctrl_exe_t exe;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  // Control constants laid out as {wb[1:0], mem[2:0], exe[2:0]}
  localparam ctrl_t CTRL_NONE   = 8'b00_000_000;
  localparam ctrl_t CTRL_OP     = 8'b01_000_100;
  localparam ctrl_t CTRL_OP_IMM = 8'b01_000_101;
  localparam ctrl_t CTRL_LOAD   = 8'b11_010_001;
  localparam ctrl_t CTRL_STORE  = 8'b00_100_001;
  localparam ctrl_t CTRL_BRANCH = 8'b00_001_010;
  localparam ctrl_t CTRL_UPPER  = 8'b01_000_111;
  localparam ctrl_t CTRL_JUMP   = 8'b01_001_111;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Handshake / bus bundle between IF-ID, the decode stage and execute.
// Optional macro DECO_ILLEGAL_TRAP_EN adds the out_illegal signal.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            wb_we;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [RAW-1:0]  out_rs1;
  logic [RAW-1:0]  out_rs2;
  logic [RAW-1:0]  out_rd;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [1:0]      out_ctrl_wb;
  logic [2:0]      out_ctrl_mem;
  logic [2:0]      out_ctrl_exe;
`ifdef DECO_ILLEGAL_TRAP_EN
  logic            out_illegal;
`endif

  // Upstream/downstream side (fetch, writeback, execute)
  modport master (
    output in_valid, in_instr, in_pc, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
    input  out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
    input  out_ctrl_wb, out_ctrl_mem, out_ctrl_exe
`ifdef DECO_ILLEGAL_TRAP_EN
    , input out_illegal
`endif
  );

  // Decode stage side
  modport slave (
    input  in_valid, in_instr, in_pc, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
    output out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
    output out_ctrl_wb, out_ctrl_mem, out_ctrl_exe
`ifdef DECO_ILLEGAL_TRAP_EN
    , output out_illegal
`endif
  );

endinterface

// File: rtl/decode_stage_pipe_imm_gen.sv
// Combinational immediate generator: selects the RV32I immediate layout
// for the given format and sign-extends it to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0] imm32;

  // Assemble the 32-bit immediate per format; R-type and unknown give 0
  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends when XLEN is 64
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage with integrated ID/EX pipeline register.
// Decodes immediates and control bundles, reads a bypassed register file,
// and handles valid/ready, load-use stall and flush.
// Optional macro DECO_ILLEGAL_TRAP_EN adds a registered out_illegal flag.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = $clog2(NREG)
) (
  input logic clk,
  input logic rst,
  decode_stage_pipe_if.slave bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RAW-1:0]  rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  ctrl_t           ctrl_dec, ctrl_d;
  imm_fmt_e        fmt;
  logic            use_rs1, use_rs2;
  logic            hazard, in_ready, load_en;

  logic [XLEN-1:0] rf_q [NREG];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RAW-1:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  ctrl_t           ctrl_q;

  assign opcode  = bus.in_instr[6:0];
  assign funct3  = bus.in_instr[14:12];
  assign funct7  = bus.in_instr[31:25];
  assign rd_idx  = bus.in_instr[7 +: RAW];
  assign rs1_idx = bus.in_instr[15 +: RAW];
  assign rs2_idx = bus.in_instr[20 +: RAW];

  // x0 reads zero; a same-cycle writeback to the read index is forwarded
  function automatic logic [XLEN-1:0] rf_read(input logic [RAW-1:0] idx,
                                              input logic [XLEN-1:0] stored,
                                              input logic we,
                                              input logic [RAW-1:0] wrd,
                                              input logic [XLEN-1:0] wdata);
    if (idx == '0)
      return '0;
    if (we && (wrd == idx))
      return wdata;
    return stored;
  endfunction

  // Opcode decode: control bundle, immediate format and source usage
  always_comb begin
    ctrl_dec = CTRL_NONE;
    fmt      = IMM_NONE;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_OP:     begin ctrl_dec = CTRL_OP;                      use_rs2 = 1'b1; end
      OPC_OP_IMM: begin ctrl_dec = CTRL_OP_IMM; fmt = IMM_I;                      end
      OPC_LOAD:   begin ctrl_dec = CTRL_LOAD;   fmt = IMM_I;                      end
      OPC_STORE:  begin ctrl_dec = CTRL_STORE;  fmt = IMM_S;     use_rs2 = 1'b1; end
      OPC_BRANCH: begin ctrl_dec = CTRL_BRANCH; fmt = IMM_B;     use_rs2 = 1'b1; end
      OPC_LUI,
      OPC_AUIPC:  begin ctrl_dec = CTRL_UPPER;  fmt = IMM_U;     use_rs1 = 1'b0; end
      OPC_JAL:    begin ctrl_dec = CTRL_JUMP;   fmt = IMM_J;     use_rs1 = 1'b0; end
      OPC_JALR:   begin ctrl_dec = CTRL_JUMP;   fmt = IMM_I;                      end
      default:    ;
    endcase
  end

`ifdef DECO_ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;

  // Flag unknown opcodes, non-base funct7 on OP, and JALR with funct3 != 0
  always_comb begin
    illegal_d = 1'b0;
    case (opcode)
      OPC_OP:     illegal_d = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      OPC_JALR:   illegal_d = (funct3 != 3'b000);
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL: illegal_d = 1'b0;
      default:    illegal_d = 1'b1;
    endcase
  end

  assign ctrl_d = illegal_d ? CTRL_NONE : ctrl_dec;
  assign bus.out_illegal = illegal_q;
`else
  assign ctrl_d = ctrl_dec;
`endif

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (bus.in_instr),
    .fmt_i   (fmt),
    .imm_o   (imm_d)
  );

  assign rs1_rd = rf_read(rs1_idx, rf_q[rs1_idx], bus.wb_we, bus.wb_rd, bus.wb_data);
  assign rs2_rd = rf_read(rs2_idx, rf_q[rs2_idx], bus.wb_we, bus.wb_rd, bus.wb_data);

  // Load-use: the load in ID/EX targets a source this instruction reads
  assign hazard = valid_q && ctrl_q.mem.mem_read && (rd_q != '0) &&
                  ((use_rs1 && (rs1_idx == rd_q)) || (use_rs2 && (rs2_idx == rd_q)));
  assign in_ready = !hazard && (!valid_q || bus.out_ready);
  assign load_en  = !bus.flush && bus.in_valid && in_ready;

  // Register file: synchronous write, x0 never written, cleared on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (bus.wb_we && (bus.wb_rd != '0)) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ID/EX valid next-state: flush, load, bubble, drain, else hold
  always_comb begin
    valid_d = valid_q;
    if (bus.flush)
      valid_d = 1'b0;
    else if (load_en)
      valid_d = 1'b1;
    else if (hazard && bus.out_ready)
      valid_d = 1'b0;
    else if (bus.out_ready && !bus.in_valid)
      valid_d = 1'b0;
  end

  // ID/EX register: valid every cycle, payload only when an instruction loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      ctrl_q     <= CTRL_NONE;
`ifdef DECO_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      if (load_en) begin
        pc_q       <= bus.in_pc;
        rs1_data_q <= rs1_rd;
        rs2_data_q <= rs2_rd;
        imm_q      <= imm_d;
        rs1_q      <= rs1_idx;
        rs2_q      <= rs2_idx;
        rd_q       <= rd_idx;
        funct3_q   <= funct3;
        funct7_q   <= funct7;
        ctrl_q     <= ctrl_d;
`ifdef DECO_ILLEGAL_TRAP_EN
        illegal_q  <= illegal_d;
`endif
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_rs1      = rs1_q;
  assign bus.out_rs2      = rs2_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_funct3   = funct3_q;
  assign bus.out_funct7   = funct7_q;
  assign bus.out_ctrl_wb  = ctrl_q.wb;
  assign bus.out_ctrl_mem = ctrl_q.mem;
  assign bus.out_ctrl_exe = ctrl_q.exe;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: table of decoded instructions plus
// hand-written reset, bypass, load-use, backpressure and flush sequences.
module tb_decode_stage_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] model [32];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        ill;
  } vec_t;

  vec_t vecs [13];

  decode_stage_pipe_if #(.XLEN(32), .RAW(5)) bus ();

  decode_stage_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [7:0]  exp_c;
    logic [31:0] pc_hold;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    //           instr          imm            wb_mem_exe    ill
    vecs[0]  = '{32'h003180B3, 32'h00000000, 8'b01_000_100, 1'b0}; // ADD x1,x3,x3
    vecs[1]  = '{32'hFFF30293, 32'hFFFFFFFF, 8'b01_000_101, 1'b0}; // ADDI x5,x6,-1
    vecs[2]  = '{32'h00712423, 32'h00000008, 8'b00_100_001, 1'b0}; // SW x7,8(x2)
    vecs[3]  = '{32'hFE320FA3, 32'hFFFFFFFF, 8'b00_100_001, 1'b0}; // SB x3,-1(x4)
    vecs[4]  = '{32'hFE000EE3, 32'hFFFFFFFC, 8'b00_001_010, 1'b0}; // BEQ -4
    vecs[5]  = '{32'h0080006F, 32'h00000008, 8'b01_001_111, 1'b0}; // JAL +8
    vecs[6]  = '{32'h12345537, 32'h12345000, 8'b01_000_111, 1'b0}; // LUI x10
    vecs[7]  = '{32'hFFFFF097, 32'hFFFFF000, 8'b01_000_111, 1'b0}; // AUIPC x1
    vecs[8]  = '{32'h004280E7, 32'h00000004, 8'b01_001_111, 1'b0}; // JALR x1,4(x5)
    vecs[9]  = '{32'h004290E7, 32'h00000004, 8'b01_001_111, 1'b1}; // JALR funct3=1
    vecs[10] = '{32'h023180B3, 32'h00000000, 8'b01_000_100, 1'b1}; // OP funct7=1
    vecs[11] = '{32'h0000007F, 32'h00000000, 8'b00_000_000, 1'b1}; // unknown opcode
    vecs[12] = '{32'h0000A103, 32'h00000000, 8'b11_010_001, 1'b0}; // LW x2,0(x1)

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.wb_we     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_pc", bus.out_pc, 0);
    chk("reset_imm", bus.out_imm, 0);
    chk("reset_ctrl", {bus.out_ctrl_wb, bus.out_ctrl_mem, bus.out_ctrl_exe}, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;

    // Preload x1..x7 through the writeback port
    for (int r = 1; r < 8; r++) begin
      bus.wb_we   = 1'b1;
      bus.wb_rd   = 5'(r);
      bus.wb_data = 32'h1000_0000 + 32'(r);
      model[r]    = 32'h1000_0000 + 32'(r);
      tick();
    end
    bus.wb_we = 1'b0;

    // Decode table
    for (int i = 0; i < 13; i++) begin
      ins = vecs[i].instr;
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      bus.in_pc    = 32'h100 + 32'(4 * i);
      #1;
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
      tick();
      exp_c = vecs[i].ctrl;
`ifdef DECO_ILLEGAL_TRAP_EN
      if (vecs[i].ill) exp_c = '0;
      chk($sformatf("v%0d_illegal", i), bus.out_illegal, vecs[i].ill);
`endif
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_pc", i), bus.out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
      chk($sformatf("v%0d_ctrl", i), {bus.out_ctrl_wb, bus.out_ctrl_mem, bus.out_ctrl_exe}, exp_c);
      chk($sformatf("v%0d_rd", i), bus.out_rd, ins[11:7]);
      chk($sformatf("v%0d_rs1", i), bus.out_rs1, ins[19:15]);
      chk($sformatf("v%0d_rs2", i), bus.out_rs2, ins[24:20]);
      chk($sformatf("v%0d_f3", i), bus.out_funct3, ins[14:12]);
      chk($sformatf("v%0d_f7", i), bus.out_funct7, ins[31:25]);
      chk($sformatf("v%0d_rs1d", i), bus.out_rs1_data, model[ins[19:15]]);
      chk($sformatf("v%0d_rs2d", i), bus.out_rs2_data, model[ins[24:20]]);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", bus.out_valid, 0);

    // Same-cycle writeback is bypassed into the load
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h003180B3;
    bus.in_pc    = 32'h200;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hDEADBEEF;
    tick();
    model[3] = 32'hDEADBEEF;
    chk("bypass_rs1d", bus.out_rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2d", bus.out_rs2_data, 32'hDEADBEEF);
    bus.in_instr = 32'h000000B3;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'hFFFFFFFF;
    tick();
    chk("x0_bypass_rs1d", bus.out_rs1_data, 0);
    bus.wb_we    = 1'b0;
    bus.in_instr = 32'h000180B3;
    tick();
    chk("x3_stored", bus.out_rs1_data, 32'hDEADBEEF);
    chk("x0_stored", bus.out_rs2_data, 0);

    // Load-use stall: LW x2 then ADD x4,x2,x2
    bus.in_instr = 32'h0000A103;
    bus.in_pc    = 32'h300;
    tick();
    chk("lw_valid", bus.out_valid, 1);
    chk("lw_mem", bus.out_ctrl_mem, 3'b010);
    bus.in_instr = 32'h00210233;
    bus.in_pc    = 32'h304;
    #1;
    chk("lu_in_ready_low", bus.in_ready, 0);
    tick();
    chk("lu_bubble", bus.out_valid, 0);
    #1;
    chk("lu_in_ready_high", bus.in_ready, 1);
    tick();
    chk("lu_add_valid", bus.out_valid, 1);
    chk("lu_add_rd", bus.out_rd, 4);
    chk("lu_add_pc", bus.out_pc, 32'h304);
    chk("lu_add_rs1d", bus.out_rs1_data, model[2]);

    // Backpressure: execute stalls for three cycles
    bus.in_instr  = 32'hFFF30293;
    bus.in_pc     = 32'h308;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), bus.in_ready, 0);
      tick();
      chk($sformatf("bp%0d_valid", k), bus.out_valid, 1);
      chk($sformatf("bp%0d_pc", k), bus.out_pc, 32'h304);
      chk($sformatf("bp%0d_rd", k), bus.out_rd, 4);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    tick();
    chk("bp_release_pc", bus.out_pc, 32'h308);
    chk("bp_release_rd", bus.out_rd, 5);

    // Flush kills ID/EX and does not load the waiting instruction
    pc_hold      = bus.out_pc;
    bus.in_instr = 32'h00712423;
    bus.in_pc    = 32'h30C;
    bus.flush    = 1'b1;
    tick();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_pc_held", bus.out_pc, pc_hold);
    bus.flush = 1'b0;
    tick();
    chk("post_flush_valid", bus.out_valid, 1);
    chk("post_flush_pc", bus.out_pc, 32'h30C);

    // Asynchronous reset mid-stream, then x5 reads back as zero
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", bus.out_valid, 0);
    chk("areset_pc", bus.out_pc, 0);
    chk("areset_imm", bus.out_imm, 0);
    chk("areset_ctrl", {bus.out_ctrl_wb, bus.out_ctrl_mem, bus.out_ctrl_exe}, 0);
    chk("areset_rd", bus.out_rd, 0);
    chk("areset_rs1d", bus.out_rs1_data, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h005280B3;
    bus.in_pc    = 32'h400;
    tick();
    chk("x5_after_reset_valid", bus.out_valid, 1);
    chk("x5_after_reset_rs1d", bus.out_rs1_data, 0);
    chk("x5_after_reset_rs2d", bus.out_rs2_data, 0);
    bus.in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised RV32I decode stage with an integrated ID/EX pipeline register. Sits between the fetch/IF-ID register and the execute stage.
- Decodes all base formats (R/I/S/B/U/J) into sign-extended immediates and WB/MEM/EXE control bundles.
- Reads a reset-able register file with write-through bypass.
- Uses a valid/ready handshake, load-use stall and flush.

Parameters:
XLEN, 32, datapath and immediate width (32 or 64)
NREG, 32, architectural register count (16 for RV32E, or 32)
RAW, $clog2(NREG), register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  IF-ID holds an instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
wb_we  in  1  writeback enable
wb_rd  in  RAW  writeback register index
wb_data  in  XLEN  writeback data
flush  in  1  kill instruction in ID/EX register and at input (branch taken)
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  execute accepts ID/EX contents
out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  registered operands and immediate
out_rs1, out_rs2, out_rd  out  RAW  registered indices
out_funct3  out  3  registered instr[14:12]
out_funct7  out  7  registered instr[31:25]
out_ctrl_wb  out  2  {MemtoReg, RegWrite}
out_ctrl_mem  out  3  {MemWrite, MemRead, Branch}
out_ctrl_exe  out  3  {AluOp[1:0], AluSrc}

Behaviour:
- Reset (rst=0, async): all outputs 0, including out_valid=0. All NREG registers are cleared.
- Register file:
  - x0 reads 0 and ignores writes.
  - Write is synchronous on wb_we && wb_rd!=0.
  - Read is combinational, with bypass: if wb_we && wb_rd==rsX && rsX!=0, read data = wb_data.
- Immediates, sign-extended to XLEN:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: 0.
- Control per opcode, as wb/mem/exe:
  - OP (0110011): 01/000/100
  - OP-IMM (0010011): 01/000/101
  - LOAD (0000011): 11/010/001
  - STORE (0100011): 00/100/001
  - BRANCH (1100011): 00/001/010
  - LUI, AUIPC: 01/000/111
  - JAL, JALR: 01/001/111
  - Unknown opcode: 00/000/000.
- Source usage:
  - rs2 is used by OP, STORE and BRANCH.
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
- Load-use hazard: out_valid && out_ctrl_mem[1] && out_rd!=0 && (out_rd matches a used source of in_instr).
- in_ready = !hazard && (!out_valid || out_ready).
- ID/EX register update, priority order:
  1. flush: out_valid <= 0 next cycle; the input is not consumed.
  2. in_valid && in_ready: load all fields, out_valid <= 1. Latency is 1 cycle.
  3. hazard && out_ready: insert bubble, out_valid <= 0.
  4. out_ready && !in_valid: out_valid <= 0.
  5. Otherwise: hold all fields.
- Payload fields change only on a load; out_valid=0 fields are don't-care, but must not be X after reset.
- A wb write in the same cycle as a load is captured by the bypass.

Optional Feature:
DECO_ILLEGAL_TRAP_EN
- Defined: adds port out_illegal (out, 1), registered with the payload. It is 1 when:
  - the opcode is not one of the nine listed, or
  - funct7 is outside {0000000, 0100000} for OP, or
  - funct3!=000 for JALR.
  Control bundles are forced to 0 when out_illegal is set.
- Undefined: port absent; unknown opcodes decode silently to all-zero control.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams
  - control-bundle typedefs (ctrl_wb_t, ctrl_mem_t, ctrl_exe_t)
  - imm_fmt_e enum (I, S, B, U, J, NONE)
  - per-opcode control constants.
- One sub-module, imm_gen: combinational, instr + imm_fmt_e -> XLEN immediate.
- Register file stays inline.

Test Plan:
1. Reset: assert rst=0 mid-stream with out_valid=1 -> out_valid=0 and all outputs 0 immediately, without waiting for a clock edge; reading x5 after release returns 0.
2. Immediates: BEQ with offset -4 (instr 0xFE000EE3) -> out_imm=0xFFFFFFFC, out_ctrl_mem=001, out_ctrl_exe=010. JAL 0x0080006F -> out_imm=8.
3. Bypass: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF in the same cycle as ADD x1,x3,x3 -> out_rs1_data=out_rs2_data=0xDEADBEEF. A write to x0 -> reads 0.
4. Load-use: LW x2,0(x1) followed by ADD x4,x2,x2 -> in_ready=0 for one cycle, one bubble (out_valid=0), then ADD issues.
5. Backpressure: out_ready=0 for 3 cycles -> outputs held stable, in_ready=0; release -> next instruction loads on the following edge.
6. Flush: flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, instruction not consumed. With DECO_ILLEGAL_TRAP_EN, opcode 0x7F -> out_illegal=1 and ctrl=0.
